// File: rtl/rr_arbiter_pkg.sv
// Shared arbitration definitions: FSM state encoding and the rotating pointer wrap helper.
package rr_arbiter_pkg;

    typedef enum logic {
        IDLE    = 1'b0,
        GRANTED = 1'b1
    } state_e;

    // Advance a channel index by one, wrapping to 0 past the last channel.
    function automatic int unsigned wrapInc(input int unsigned idx, input int unsigned channels);
        return (idx + 1 >= channels) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/rr_arbiter_if.sv
// Request/grant bundle between requesters (master) and the round-robin arbiter (slave).
// The timeout strobe exists only when RR_ARBITER_TIMEOUT_EN is defined.
interface rr_arbiter_if #(
    parameter int CHANNELS = 3
);
    localparam int INDEX_WIDTH = $clog2(CHANNELS);

    logic [CHANNELS-1:0]    request_i;
    logic                   release_i;
    logic                   grant_valid_o;
    logic [INDEX_WIDTH-1:0] grant_index_o;
`ifdef RR_ARBITER_TIMEOUT_EN
    logic                   timeout_o;
`endif

    modport master (
        output request_i,
        output release_i,
        input  grant_valid_o,
        input  grant_index_o
`ifdef RR_ARBITER_TIMEOUT_EN
        ,
        input  timeout_o
`endif
    );

    modport slave (
        input  request_i,
        input  release_i,
        output grant_valid_o,
        output grant_index_o
`ifdef RR_ARBITER_TIMEOUT_EN
        ,
        output timeout_o
`endif
    );

endinterface

// File: rtl/rr_arbiter_pick.sv
// Rotating first-set search: finds the first requesting channel at or after ptr_i, wrapping.
module rr_pick #(
    parameter int CHANNELS    = 3,
    parameter int INDEX_WIDTH = $clog2(CHANNELS)
) (
    input  logic [CHANNELS-1:0]    request_i,
    input  logic [INDEX_WIDTH-1:0] ptr_i,
    output logic                   found_o,
    output logic [INDEX_WIDTH-1:0] index_o
);

    localparam int SUM_W = INDEX_WIDTH + 1;

    logic [SUM_W-1:0]       sum;
    logic [INDEX_WIDTH-1:0] cand;

    // Walk offsets from farthest to nearest so the nearest set bit is written last and wins.
    always_comb begin
        found_o = 1'b0;
        index_o = '0;
        sum     = '0;
        cand    = '0;
        for (int off = CHANNELS - 1; off >= 0; off--) begin
            sum = {1'b0, ptr_i} + SUM_W'(off);
            if (sum >= SUM_W'(CHANNELS)) begin
                sum = sum - SUM_W'(CHANNELS);
            end
            cand = sum[INDEX_WIDTH-1:0];
            if (request_i[cand]) begin
                found_o = 1'b1;
                index_o = cand;
            end
        end
    end

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter with registered grant index/valid and a rotating priority pointer.
// Optional forced-release hold timeout is enabled by defining RR_ARBITER_TIMEOUT_EN.
module rr_arbiter
    import rr_arbiter_pkg::*;
#(
    parameter int CHANNELS = 3,
    parameter int MAX_HOLD = 16
) (
    input logic        clk,
    input logic        rst,
    rr_arbiter_if.slave arb
);

    localparam int INDEX_WIDTH = $clog2(CHANNELS);

    if (CHANNELS < 2) begin : g_bad_channels
        $error("rr_arbiter: CHANNELS must be at least 2");
    end
    if (MAX_HOLD < 1) begin : g_bad_hold
        $error("rr_arbiter: MAX_HOLD must be at least 1");
    end

    state_e                 state_q, state_d;
    logic [INDEX_WIDTH-1:0] ptr_q, ptr_d;
    logic [INDEX_WIDTH-1:0] grantIndex_q, grantIndex_d;
    logic [INDEX_WIDTH-1:0] nextPtr;
    logic                   pickFound;
    logic [INDEX_WIDTH-1:0] pickIndex;
    logic                   ownerDone;

`ifdef RR_ARBITER_TIMEOUT_EN
    localparam int HOLD_W = $clog2(MAX_HOLD + 1);

    logic [HOLD_W-1:0] holdCnt_q, holdCnt_d;
    logic              timeout_q, timeout_d;
`endif

    rr_pick #(
        .CHANNELS    (CHANNELS),
        .INDEX_WIDTH (INDEX_WIDTH)
    ) u_pick (
        .request_i (arb.request_i),
        .ptr_i     (ptr_q),
        .found_o   (pickFound),
        .index_o   (pickIndex)
    );

    assign nextPtr   = INDEX_WIDTH'(wrapInc(32'(grantIndex_q), CHANNELS));
    assign ownerDone = arb.release_i || !arb.request_i[grantIndex_q];

    // Grants are non-preemptive; every exit from GRANTED passes through IDLE, giving the one-cycle gap.
    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        grantIndex_d = grantIndex_q;
`ifdef RR_ARBITER_TIMEOUT_EN
        holdCnt_d    = holdCnt_q;
        timeout_d    = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (pickFound) begin
                    state_d      = GRANTED;
                    grantIndex_d = pickIndex;
`ifdef RR_ARBITER_TIMEOUT_EN
                    holdCnt_d    = '0;
`endif
                end
            end
            GRANTED: begin
                if (ownerDone) begin
                    state_d = IDLE;
                    ptr_d   = nextPtr;
                end
`ifdef RR_ARBITER_TIMEOUT_EN
                else if (holdCnt_q == HOLD_W'(MAX_HOLD - 1)) begin
                    state_d   = IDLE;
                    ptr_d     = nextPtr;
                    timeout_d = 1'b1;
                end else begin
                    holdCnt_d = holdCnt_q + 1'b1;
                end
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            ptr_q        <= '0;
            grantIndex_q <= '0;
`ifdef RR_ARBITER_TIMEOUT_EN
            holdCnt_q    <= '0;
            timeout_q    <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            grantIndex_q <= grantIndex_d;
`ifdef RR_ARBITER_TIMEOUT_EN
            holdCnt_q    <= holdCnt_d;
            timeout_q    <= timeout_d;
`endif
        end
    end

    assign arb.grant_valid_o = (state_q == GRANTED);
    assign arb.grant_index_o = grantIndex_q;
`ifdef RR_ARBITER_TIMEOUT_EN
    assign arb.timeout_o     = timeout_q;
`endif

endmodule

// File: tb/tb_rr_arbiter.sv
// Directed self-checking bench for rr_arbiter (3 channels, MAX_HOLD=4).
// Timeout scenario runs only when RR_ARBITER_TIMEOUT_EN is defined.
module tb_rr_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    rr_arbiter_if #(.CHANNELS(3)) bus ();

    rr_arbiter #(
        .CHANNELS (3),
        .MAX_HOLD (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .arb (bus)
    );

    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic waitEdge();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        bus.request_i = 3'b111;
        bus.release_i = 1'b0;
        for (int k = 0; k < 3; k++) begin
            waitEdge();
            checks++;
            if (bus.grant_valid_o !== 1'b0 || bus.grant_index_o !== 2'd0) begin
                errors++;
                $display("[TB] FAIL reset_hold: got valid=%b index=%0d, expected valid=0 index=0",
                         bus.grant_valid_o, bus.grant_index_o);
            end
        end
        rst = 1'b0;
        waitEdge();
        checks++;
        if (bus.grant_valid_o !== 1'b1 || bus.grant_index_o !== 2'd0) begin
            errors++;
            $display("[TB] FAIL reset_first_grant: got valid=%b index=%0d, expected valid=1 index=0",
                     bus.grant_valid_o, bus.grant_index_o);
        end
        bus.release_i = 1'b1;
        bus.request_i = 3'b000;
        waitEdge();
        bus.release_i = 1'b0;
        checks++;
        if (bus.grant_valid_o !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_release: got valid=%b, expected 0", bus.grant_valid_o);
        end
    endtask

    task automatic test_single_grant();
        bus.request_i = 3'b010;
        for (int k = 0; k < 5; k++) begin
            waitEdge();
            checks++;
            if (bus.grant_valid_o !== 1'b1 || bus.grant_index_o !== 2'd1) begin
                errors++;
                $display("[TB] FAIL single_hold cycle %0d: got valid=%b index=%0d, expected valid=1 index=1",
                         k, bus.grant_valid_o, bus.grant_index_o);
            end
        end
        bus.release_i = 1'b1;
        waitEdge();
        bus.release_i = 1'b0;
        bus.request_i = 3'b000;
        checks++;
        if (bus.grant_valid_o !== 1'b0 || bus.grant_index_o !== 2'd1) begin
            errors++;
            $display("[TB] FAIL single_release: got valid=%b index=%0d, expected valid=0 index=1",
                     bus.grant_valid_o, bus.grant_index_o);
        end
    endtask

    task automatic test_wrap();
        bus.request_i = 3'b011;
        waitEdge();
        checks++;
        if (bus.grant_valid_o !== 1'b1 || bus.grant_index_o !== 2'd0) begin
            errors++;
            $display("[TB] FAIL wrap_from_ptr2: got valid=%b index=%0d, expected valid=1 index=0",
                     bus.grant_valid_o, bus.grant_index_o);
        end
        bus.release_i = 1'b1;
        bus.request_i = 3'b000;
        waitEdge();
        bus.release_i = 1'b0;
    endtask

    task automatic test_rotation();
        int expIdx[5] = '{0, 1, 2, 0, 1};
        rst = 1'b1;
        #2;
        rst = 1'b0;
        bus.request_i = 3'b111;
        for (int k = 0; k < 5; k++) begin
            waitEdge();
            checks++;
            if (bus.grant_valid_o !== 1'b1 || bus.grant_index_o !== 2'(expIdx[k])) begin
                errors++;
                $display("[TB] FAIL rotation grant %0d: got valid=%b index=%0d, expected valid=1 index=%0d",
                         k, bus.grant_valid_o, bus.grant_index_o, expIdx[k]);
            end
            bus.release_i = 1'b1;
            waitEdge();
            bus.release_i = 1'b0;
            checks++;
            if (bus.grant_valid_o !== 1'b0 || bus.grant_index_o !== 2'(expIdx[k])) begin
                errors++;
                $display("[TB] FAIL rotation gap %0d: got valid=%b index=%0d, expected valid=0 index=%0d",
                         k, bus.grant_valid_o, bus.grant_index_o, expIdx[k]);
            end
        end
        bus.request_i = 3'b000;
        waitEdge();
    endtask

    task automatic test_request_drop();
        bus.request_i = 3'b010;
        waitEdge();
        waitEdge();
        checks++;
        if (bus.grant_valid_o !== 1'b1 || bus.grant_index_o !== 2'd1) begin
            errors++;
            $display("[TB] FAIL drop_held: got valid=%b index=%0d, expected valid=1 index=1",
                     bus.grant_valid_o, bus.grant_index_o);
        end
        bus.request_i = 3'b000;
        waitEdge();
        checks++;
        if (bus.grant_valid_o !== 1'b0) begin
            errors++;
            $display("[TB] FAIL drop_release: got valid=%b, expected 0", bus.grant_valid_o);
        end
    endtask

    task automatic test_simultaneous();
        bus.request_i = 3'b001;
        waitEdge();
        checks++;
        if (bus.grant_valid_o !== 1'b1 || bus.grant_index_o !== 2'd0) begin
            errors++;
            $display("[TB] FAIL simul_first: got valid=%b index=%0d, expected valid=1 index=0",
                     bus.grant_valid_o, bus.grant_index_o);
        end
        bus.release_i = 1'b1;
        bus.request_i = 3'b101;
        waitEdge();
        bus.release_i = 1'b0;
        checks++;
        if (bus.grant_valid_o !== 1'b0) begin
            errors++;
            $display("[TB] FAIL simul_release_wins: got valid=%b, expected 0", bus.grant_valid_o);
        end
        waitEdge();
        checks++;
        if (bus.grant_valid_o !== 1'b1 || bus.grant_index_o !== 2'd2) begin
            errors++;
            $display("[TB] FAIL simul_next: got valid=%b index=%0d, expected valid=1 index=2",
                     bus.grant_valid_o, bus.grant_index_o);
        end
        bus.release_i = 1'b1;
        bus.request_i = 3'b000;
        waitEdge();
        bus.release_i = 1'b0;
    endtask

    task automatic test_async_reset();
        bus.request_i = 3'b010;
        waitEdge();
        bus.release_i = 1'b1;
        bus.request_i = 3'b000;
        waitEdge();
        bus.release_i = 1'b0;
        bus.request_i = 3'b100;
        waitEdge();
        checks++;
        if (bus.grant_valid_o !== 1'b1 || bus.grant_index_o !== 2'd2) begin
            errors++;
            $display("[TB] FAIL async_pre: got valid=%b index=%0d, expected valid=1 index=2",
                     bus.grant_valid_o, bus.grant_index_o);
        end
        #3;
        rst = 1'b1;
        #1;
        checks++;
        if (bus.grant_valid_o !== 1'b0 || bus.grant_index_o !== 2'd0) begin
            errors++;
            $display("[TB] FAIL async_drop: got valid=%b index=%0d, expected valid=0 index=0",
                     bus.grant_valid_o, bus.grant_index_o);
        end
        bus.request_i = 3'b110;
        waitEdge();
        rst = 1'b0;
        waitEdge();
        checks++;
        if (bus.grant_valid_o !== 1'b1 || bus.grant_index_o !== 2'd1) begin
            errors++;
            $display("[TB] FAIL async_ptr_cleared: got valid=%b index=%0d, expected valid=1 index=1",
                     bus.grant_valid_o, bus.grant_index_o);
        end
        bus.release_i = 1'b1;
        bus.request_i = 3'b000;
        waitEdge();
        bus.release_i = 1'b0;
    endtask

`ifdef RR_ARBITER_TIMEOUT_EN
    task automatic test_timeout();
        bus.request_i = 3'b001;
        for (int k = 0; k < 4; k++) begin
            waitEdge();
            checks++;
            if (bus.grant_valid_o !== 1'b1 || bus.grant_index_o !== 2'd0 || bus.timeout_o !== 1'b0) begin
                errors++;
                $display("[TB] FAIL timeout_hold cycle %0d: got valid=%b index=%0d timeout=%b, expected 1/0/0",
                         k, bus.grant_valid_o, bus.grant_index_o, bus.timeout_o);
            end
        end
        waitEdge();
        checks++;
        if (bus.grant_valid_o !== 1'b0 || bus.timeout_o !== 1'b1) begin
            errors++;
            $display("[TB] FAIL timeout_fire: got valid=%b timeout=%b, expected valid=0 timeout=1",
                     bus.grant_valid_o, bus.timeout_o);
        end
        waitEdge();
        checks++;
        if (bus.grant_valid_o !== 1'b1 || bus.grant_index_o !== 2'd0 || bus.timeout_o !== 1'b0) begin
            errors++;
            $display("[TB] FAIL timeout_regrant: got valid=%b index=%0d timeout=%b, expected 1/0/0",
                     bus.grant_valid_o, bus.grant_index_o, bus.timeout_o);
        end
        bus.request_i = 3'b000;
        waitEdge();
    endtask
`endif

    initial begin
        test_reset();
        test_single_grant();
        test_wrap();
        test_rotation();
        test_request_drop();
        test_simultaneous();
        test_async_reset();
`ifdef RR_ARBITER_TIMEOUT_EN
        test_timeout();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
